// File: rtl/decode_queue.sv
// DEPTH-entry fetch-to-dispatch instruction queue that decodes its head entry.
// Define DECODE_QUEUE_ILLEGAL_EN to enable unknown-opcode flagging on OUT_ILLEGAL.
module decode_queue #(
  parameter int DEPTH       = 4,
  parameter int IMM_SIGNEXT = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     MEM_WAIT,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [31:0]              IN_PC,
  input  logic [31:0]              IN_INST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [31:0]              OUT_PC,
  output logic [16:0]              OUT_OPCODE,
  output logic [4:0]               OUT_RD,
  output logic [4:0]               OUT_RS1,
  output logic [4:0]               OUT_RS2,
  output logic [31:0]              OUT_IMM,
  output logic                     OUT_ILLEGAL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          clear;
  logic [31:0]   head_inst;
  logic [6:0]    op;
  logic          sx;

  assign clear     = !RST_N || FLUSH;
  assign IN_READY  = (count != CW'(DEPTH));
  assign OUT_VALID = (count != '0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY && !MEM_WAIT;
  assign COUNT     = count;

  always_ff @(posedge CLK) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observable once count covers it.
  always_ff @(posedge CLK) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]   <= IN_PC;
      inst_mem[wr_ptr] <= IN_INST;
    end
  end

  // An empty queue presents a NOP at PC 0 so downstream decode stays benign.
  assign head_inst  = OUT_VALID ? inst_mem[rd_ptr] : 32'h0000_0013;
  assign OUT_PC     = OUT_VALID ? pc_mem[rd_ptr] : 32'h0;
  assign op         = head_inst[6:0];
  assign OUT_OPCODE = {head_inst[6:0], head_inst[14:12], head_inst[31:25]};
  assign OUT_RD     = head_inst[11:7];
  assign OUT_RS1    = head_inst[19:15];
  assign OUT_RS2    = head_inst[24:20];
  assign sx         = (IMM_SIGNEXT != 0) && head_inst[31];

  always_comb begin
    OUT_IMM = 32'hFFFF_FFFF;
    case (op)
      OP_R:
        OUT_IMM = 32'h0;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
        OUT_IMM = {{20{sx}}, head_inst[31:20]};
      OP_STORE:
        OUT_IMM = {{20{sx}}, head_inst[31:25], head_inst[11:7]};
      OP_BRANCH:
        OUT_IMM = {{19{sx}}, head_inst[31], head_inst[7], head_inst[30:25],
                   head_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        OUT_IMM = {head_inst[31:12], 12'h0};
      OP_JAL:
        OUT_IMM = {{11{sx}}, head_inst[31], head_inst[19:12], head_inst[20],
                   head_inst[30:21], 1'b0};
      default:
        OUT_IMM = 32'hFFFF_FFFF;
    endcase
  end

`ifdef DECODE_QUEUE_ILLEGAL_EN
  logic known_op;

  always_comb begin
    known_op = 1'b0;
    case (op)
      OP_R, OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM,
      OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL:
        known_op = 1'b1;
      default:
        known_op = 1'b0;
    endcase
  end

  assign OUT_ILLEGAL = OUT_VALID && (!known_op || head_inst == 32'h0 ||
                                     head_inst == 32'hFFFF_FFFF);
`else
  assign OUT_ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue; a second instance with
// IMM_SIGNEXT=0 shares the stimulus so both immediate modes are checked.
module tb_decode_queue;

  logic        CLK = 1'b0;
  logic        RST_N, FLUSH, MEM_WAIT, IN_VALID, OUT_READY;
  logic [31:0] IN_PC, IN_INST;
  logic        IN_READY, OUT_VALID, OUT_ILLEGAL;
  logic [31:0] OUT_PC, OUT_IMM;
  logic [16:0] OUT_OPCODE;
  logic [4:0]  OUT_RD, OUT_RS1, OUT_RS2;
  logic [2:0]  COUNT;

  logic        z_in_ready, z_out_valid, z_out_illegal;
  logic [31:0] z_out_pc, z_out_imm;
  logic [16:0] z_out_opcode;
  logic [4:0]  z_out_rd, z_out_rs1, z_out_rs2;
  logic [2:0]  z_count;

  int checks   = 0;
  int failures = 0;

`ifdef DECODE_QUEUE_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  always #5 CLK = ~CLK;

  decode_queue #(.DEPTH(4), .IMM_SIGNEXT(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PC(IN_PC), .IN_INST(IN_INST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
    .OUT_OPCODE(OUT_OPCODE), .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
    .OUT_IMM(OUT_IMM), .OUT_ILLEGAL(OUT_ILLEGAL), .COUNT(COUNT)
  );

  decode_queue #(.DEPTH(4), .IMM_SIGNEXT(0)) dut_z (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .IN_VALID(IN_VALID), .IN_READY(z_in_ready), .IN_PC(IN_PC), .IN_INST(IN_INST),
    .OUT_VALID(z_out_valid), .OUT_READY(OUT_READY), .OUT_PC(z_out_pc),
    .OUT_OPCODE(z_out_opcode), .OUT_RD(z_out_rd), .OUT_RS1(z_out_rs1),
    .OUT_RS2(z_out_rs2), .OUT_IMM(z_out_imm), .OUT_ILLEGAL(z_out_illegal),
    .COUNT(z_count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    IN_VALID = 1'b1;
    IN_PC    = pc;
    IN_INST  = inst;
    tick();
    IN_VALID = 1'b0;
  endtask

  // Decode vectors: inst, sign-extended imm, zero-extended imm, rd, rs1, rs2
  logic [31:0] vec_inst [5] = '{32'hFE20AC23, 32'h123452B7, 32'hFF9FF06F, 32'h002081B3, 32'hFE000EE3};
  logic [31:0] vec_simm [5] = '{32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFFC};
  logic [31:0] vec_zimm [5] = '{32'h00000FF8, 32'h12345000, 32'h001FFFF8, 32'h00000000, 32'h00001FFC};
  logic [4:0]  vec_rd   [5] = '{5'd24, 5'd5, 5'd0, 5'd3, 5'd29};
  logic [4:0]  vec_rs1  [5] = '{5'd1, 5'd8, 5'd31, 5'd1, 5'd0};
  logic [4:0]  vec_rs2  [5] = '{5'd2, 5'd3, 5'd25, 5'd2, 5'd0};

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0; IN_VALID = 1'b0;
    OUT_READY = 1'b0; IN_PC = '0; IN_INST = '0;

    // Reset held two cycles
    tick(); tick();
    RST_N = 1'b1;
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_ready", 32'(IN_READY), 32'd1);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_pc", OUT_PC, 32'h0);
    check("rst_imm", OUT_IMM, 32'h0);
    check("rst_opcode", 32'(OUT_OPCODE), 32'h4C00);
    check("rst_illegal", 32'(OUT_ILLEGAL), 32'd0);

    // Single addi with negative immediate
    push_one(32'h100, 32'hFFF00093);
    check("addi_valid", 32'(OUT_VALID), 32'd1);
    check("addi_pc", OUT_PC, 32'h100);
    check("addi_rd", 32'(OUT_RD), 32'd1);
    check("addi_rs1", 32'(OUT_RS1), 32'd0);
    check("addi_rs2", 32'(OUT_RS2), 32'd31);
    check("addi_opcode", 32'(OUT_OPCODE), 32'h4C7F);
    check("addi_imm_s", OUT_IMM, 32'hFFFFFFFF);
    check("addi_imm_z", z_out_imm, 32'h00000FFF);
    tick(); tick();
    check("addi_hold_pc", OUT_PC, 32'h100);
    check("addi_hold_cnt", 32'(COUNT), 32'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("addi_pop_cnt", 32'(COUNT), 32'd0);
    check("addi_pop_valid", 32'(OUT_VALID), 32'd0);

    // Fill to full, fifth offer held until space frees
    for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i), 32'h13 | (32'(i) << 20));
    check("full_count", 32'(COUNT), 32'd4);
    check("full_ready", 32'(IN_READY), 32'd0);
    IN_VALID = 1'b1; IN_PC = 32'h210; IN_INST = 32'h00400013;
    tick();
    check("full_held_cnt", 32'(COUNT), 32'd4);
    check("full_held_pc", OUT_PC, 32'h200);
    OUT_READY = 1'b1;
    tick();
    check("drain0_cnt", 32'(COUNT), 32'd3);
    check("drain0_ready", 32'(IN_READY), 32'd1);
    check("drain0_pc", OUT_PC, 32'h204);
    check("drain0_imm", OUT_IMM, 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("drain1_cnt", 32'(COUNT), 32'd3);
    check("drain1_pc", OUT_PC, 32'h208);
    tick();
    check("drain2_pc", OUT_PC, 32'h20C);
    tick();
    check("drain3_pc", OUT_PC, 32'h210);
    check("drain3_imm", OUT_IMM, 32'd4);
    tick();
    check("drain4_cnt", 32'(COUNT), 32'd0);
    OUT_READY = 1'b0;

    // Steady push+pop at COUNT=2 across pointer wrap
    push_one(32'h300, 32'h13);
    push_one(32'h304, 32'h13);
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_INST = 32'h13;
    for (int k = 0; k < 10; k++) begin
      IN_PC = 32'h308 + 32'(4 * k);
      check("stream_pc", OUT_PC, 32'h300 + 32'(4 * k));
      tick();
      check("stream_cnt", 32'(COUNT), 32'd2);
    end
    MEM_WAIT = 1'b1;
    IN_PC = 32'h330; tick();
    IN_PC = 32'h334; tick();
    check("wait_cnt", 32'(COUNT), 32'd4);
    check("wait_ready", 32'(IN_READY), 32'd0);
    check("wait_pc", OUT_PC, 32'h328);
    IN_VALID = 1'b0;
    MEM_WAIT = 1'b0;

    // Flush with COUNT=3 and a concurrent push offer
    tick();
    OUT_READY = 1'b0;
    check("preflush_cnt", 32'(COUNT), 32'd3);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_PC = 32'h400; IN_INST = 32'h13;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check("flush_cnt", 32'(COUNT), 32'd0);
    check("flush_valid", 32'(OUT_VALID), 32'd0);
    check("flush_ready", 32'(IN_READY), 32'd1);
    check("flush_pc", OUT_PC, 32'h0);
    tick();
    check("flush_after_cnt", 32'(COUNT), 32'd0);

    // Reset mid-burst clears and drops the concurrent push
    push_one(32'h480, 32'h13);
    RST_N = 1'b0; IN_VALID = 1'b1; IN_PC = 32'h484;
    tick();
    RST_N = 1'b1; IN_VALID = 1'b0;
    check("midrst_cnt", 32'(COUNT), 32'd0);

    // Immediate formats across S/U/J/R/B
    for (int v = 0; v < 5; v++) begin
      push_one(32'h500 + 32'(4 * v), vec_inst[v]);
      check("fmt_imm_s", OUT_IMM, vec_simm[v]);
      check("fmt_imm_z", z_out_imm, vec_zimm[v]);
      check("fmt_rd", 32'(OUT_RD), 32'(vec_rd[v]));
      check("fmt_rs1", 32'(OUT_RS1), 32'(vec_rs1[v]));
      check("fmt_rs2", 32'(OUT_RS2), 32'(vec_rs2[v]));
      check("fmt_illegal", 32'(OUT_ILLEGAL), 32'd0);
      OUT_READY = 1'b1; tick(); OUT_READY = 1'b0;
    end

    // All-zero instruction: unknown opcode
    push_one(32'h600, 32'h00000000);
    check("zero_imm", OUT_IMM, 32'hFFFFFFFF);
    check("zero_illegal", 32'(OUT_ILLEGAL), 32'(ILL_EXP));
    OUT_READY = 1'b1; tick(); OUT_READY = 1'b0;
    push_one(32'h604, 32'hFFFFFFFF);
    check("ones_illegal", 32'(OUT_ILLEGAL), 32'(ILL_EXP));
    OUT_READY = 1'b1; tick(); OUT_READY = 1'b0;
    check("end_illegal", 32'(OUT_ILLEGAL), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
